// File: rtl/instr_mem_loader.sv
// Word-organised instruction memory with a big-endian byte-stream loader and a registered fetch port.
// Optional macro IMEM_BOUNDS_CHECK_EN turns misaligned or out-of-program fetches into a flagged NOP.
module instr_mem_loader #(
    parameter int                NBITS     = 32,
    parameter int                ADDR_BITS = 8,
    parameter logic [NBITS-1:0]  HALT_WORD = 32'hFFFF_FFFF
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_load_start,
    input  logic                 i_load_valid,
    input  logic [7:0]           i_load_byte,
    output logic                 o_load_ready,
    output logic                 o_load_done,
    output logic [ADDR_BITS:0]   o_word_count,
    input  logic [NBITS-1:0]     i_pc,
    input  logic                 i_step,
    output logic [NBITS-1:0]     o_instr,
    output logic                 o_halt,
    output logic                 o_addr_err
);

    localparam int DEPTH = 1 << ADDR_BITS;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOADING,
        S_RUN
    } state_e;

    state_e                 state_q;
    logic [1:0]             byte_cnt_q;
    logic [NBITS-1:0]       asm_q;
    logic [ADDR_BITS:0]     wr_ptr_q;
    logic [NBITS-1:0]       instr_q;
    logic                   halt_q;
    logic                   addr_err_q;

    logic [NBITS-1:0]       mem [DEPTH];

    logic                   byte_acc;
    logic                   word_we;
    logic [NBITS-1:0]       word_d;
    logic [ADDR_BITS-1:0]   wr_idx;
    logic [ADDR_BITS-1:0]   rd_idx;
    logic [NBITS-1:0]       rd_word;
    logic                   fetch_ok;

    // PC bits outside the word index only matter to the bounds check.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{i_pc[NBITS-1:ADDR_BITS+2], i_pc[1:0]};

    // NOTE: every signal driven in always_comb gets a default first, so no latch can be inferred.
    always_comb begin
        byte_acc = 1'b0;
        word_we  = 1'b0;
        word_d   = {asm_q[NBITS-9:0], i_load_byte};
        wr_idx   = wr_ptr_q[ADDR_BITS-1:0];
        rd_idx   = i_pc[ADDR_BITS+1:2];
        rd_word  = mem[rd_idx];
        fetch_ok = 1'b1;

        // A start in the same cycle wins over the byte strobe.
        byte_acc = i_load_valid && (state_q == S_LOADING) && !i_load_start;
        word_we  = byte_acc && (byte_cnt_q == 2'd3);
`ifdef IMEM_BOUNDS_CHECK_EN
        fetch_ok = (i_pc[1:0] == 2'b00) && ({1'b0, rd_idx} < wr_ptr_q);
`endif
    end

    // NOTE: the memory array has no reset; only the pointer guarding it does.
    always_ff @(posedge i_clk) begin
        if (word_we) begin
            mem[wr_idx] <= word_d;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q    <= S_IDLE;
            byte_cnt_q <= '0;
            asm_q      <= '0;
            wr_ptr_q   <= '0;
            instr_q    <= '0;
            halt_q     <= 1'b0;
            addr_err_q <= 1'b0;
        end else if (i_load_start) begin
            state_q    <= S_LOADING;
            byte_cnt_q <= '0;
            asm_q      <= '0;
            wr_ptr_q   <= '0;
            instr_q    <= '0;
            halt_q     <= 1'b0;
            addr_err_q <= 1'b0;
        end else begin
            case (state_q)
                S_LOADING: begin
                    if (byte_acc) begin
                        byte_cnt_q <= byte_cnt_q + 2'd1;
                        asm_q      <= word_d;
                    end
                    if (word_we) begin
                        wr_ptr_q <= wr_ptr_q + 1'b1;
                        // Terminate on the halt word or once the last slot is filled.
                        if ((word_d == HALT_WORD) || (wr_idx == ADDR_BITS'(DEPTH - 1))) begin
                            state_q <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    if (i_step) begin
                        if (fetch_ok) begin
                            instr_q    <= rd_word;
                            halt_q     <= (rd_word == HALT_WORD);
                            addr_err_q <= 1'b0;
                        end else begin
                            instr_q    <= '0;
                            halt_q     <= 1'b0;
                            addr_err_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign o_load_ready = (state_q != S_RUN);
    assign o_load_done  = (state_q == S_RUN);
    assign o_word_count = wr_ptr_q;
    assign o_instr      = instr_q;
    assign o_halt       = halt_q;
    assign o_addr_err   = addr_err_q;

endmodule
